// File: rtl/row_sched.sv
// Open-row scheduler: tracks one open row per {bg,ba} and sequences PRE/ACT/CAS
// and PREA/REF strobes with the ACT, precharge, CAS and refresh spacing.
module row_sched #(
    parameter int TRCD = 11,
    parameter int TRP  = 11,
    parameter int TCCD = 4,
    parameter int TRFC = 208
) (
    input  logic        CK_c,
    input  logic        reset,
    input  logic        cmd_rdy,
    input  logic [2:0]  req_in,
    input  logic [1:0]  bg_in,
    input  logic [1:0]  ba_in,
    input  logic [13:0] row_in,
    input  logic [9:0]  col_in,
    input  logic        refresh_req,
    output logic        busy,
    output logic        pre_rdy,
    output logic        prea_rdy,
    output logic        act_rdy,
    output logic        no_act_rdy,
    output logic        cas_rdy,
    output logic        refresh_rdy,
    output logic        refresh_ack,
    output logic [1:0]  bg_out,
    output logic [1:0]  ba_out,
    output logic [13:0] row_out,
    output logic [9:0]  col_out,
    output logic [2:0]  req_out
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_DECODE, ST_PRE, ST_WAIT_RP, ST_ACT, ST_WAIT_RCD,
        ST_CAS, ST_WAIT_CCD, ST_PREA, ST_WAIT_PREA, ST_REF, ST_WAIT_RFC
    } state_t;

    localparam logic [7:0] LD_RCD = 8'(TRCD - 1);
    localparam logic [7:0] LD_RP  = 8'(TRP - 1);
    localparam logic [7:0] LD_CCD = 8'(TCCD - 1);
    localparam logic [7:0] LD_RFC = 8'(TRFC - 1);

    state_t      r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next, w_cnt_dec;
    logic        w_cnt_last;
    logic [15:0] r_valid, w_valid_next;
    logic [13:0] r_row_tbl [16];
    logic        r_busy;
    logic        r_pre, r_prea, r_act, r_no_act, r_cas, r_ref, r_ack;
    logic        w_pre, w_prea, w_act, w_no_act, w_cas, w_ref, w_ack;
    logic        w_capture, w_row_we, w_hit;
    logic [1:0]  r_bg, r_ba;
    logic [13:0] r_row;
    logic [9:0]  r_col;
    logic [2:0]  r_req;
    logic [3:0]  w_idx;

    assign w_idx     = {r_bg, r_ba};
    assign w_hit     = (r_row_tbl[w_idx] == r_row);
    assign w_cnt_dec = (r_cnt == 8'd0) ? 8'd0 : r_cnt - 8'd1;
    // Short waits leave as the counter steps to zero, so strobe spacing equals
    // the parameter; a count of 0 still spends one cycle in the wait state.
    assign w_cnt_last = (r_cnt <= 8'd1);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_valid_next = r_valid;
        w_row_we     = 1'b0;
        w_capture    = 1'b0;
        w_pre        = 1'b0;
        w_prea       = 1'b0;
        w_act        = 1'b0;
        w_no_act     = 1'b0;
        w_cas        = 1'b0;
        w_ref        = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (refresh_req) begin
                    w_state_next = (|r_valid) ? ST_PREA : ST_REF;
                end else if (cmd_rdy && req_in >= 3'd1 && req_in <= 3'd4) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (r_valid[w_idx] && w_hit) begin
                    w_no_act     = 1'b1;
                    w_state_next = ST_CAS;
                end else if (!r_valid[w_idx]) begin
                    w_state_next = ST_ACT;
                end else begin
                    w_state_next = ST_PRE;
                end
            end
            ST_PRE: begin
                w_pre                = 1'b1;
                w_valid_next[w_idx]  = 1'b0;
                w_cnt_next           = LD_RP;
                w_state_next         = ST_WAIT_RP;
            end
            ST_WAIT_RP: begin
                w_cnt_next = w_cnt_dec;
                if (w_cnt_last) w_state_next = ST_ACT;
            end
            ST_ACT: begin
                w_act               = 1'b1;
                w_row_we            = 1'b1;
                w_valid_next[w_idx] = 1'b1;
                w_cnt_next          = LD_RCD;
                w_state_next        = ST_WAIT_RCD;
            end
            ST_WAIT_RCD: begin
                w_cnt_next = w_cnt_dec;
                if (w_cnt_last) w_state_next = ST_CAS;
            end
            ST_CAS: begin
                w_cas = 1'b1;
                if (r_req == 3'd3 || r_req == 3'd4) w_valid_next[w_idx] = 1'b0;
                w_cnt_next   = LD_CCD;
                w_state_next = ST_WAIT_CCD;
            end
            ST_WAIT_CCD: begin
                w_cnt_next = w_cnt_dec;
                if (w_cnt_last) w_state_next = ST_IDLE;
            end
            ST_PREA: begin
                w_prea       = 1'b1;
                w_valid_next = '0;
                w_cnt_next   = LD_RP;
                w_state_next = ST_WAIT_PREA;
            end
            ST_WAIT_PREA: begin
                w_cnt_next = w_cnt_dec;
                if (w_cnt_last) w_state_next = ST_REF;
            end
            ST_REF: begin
                w_ref        = 1'b1;
                w_cnt_next   = LD_RFC;
                w_state_next = ST_WAIT_RFC;
            end
            ST_WAIT_RFC: begin
                // Refresh runs until the counter reads zero so refresh_ack closes
                // the full refresh window rather than the command gap.
                w_cnt_next = w_cnt_dec;
                if (r_cnt == 8'd0) begin
                    w_ack        = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK_c or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 8'd0;
            r_valid  <= '0;
            r_busy   <= 1'b0;
            r_pre    <= 1'b0;
            r_prea   <= 1'b0;
            r_act    <= 1'b0;
            r_no_act <= 1'b0;
            r_cas    <= 1'b0;
            r_ref    <= 1'b0;
            r_ack    <= 1'b0;
            r_bg     <= 2'd0;
            r_ba     <= 2'd0;
            r_row    <= 14'd0;
            r_col    <= 10'd0;
            r_req    <= 3'd0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_valid  <= w_valid_next;
            r_busy   <= (r_state != ST_IDLE);
            r_pre    <= w_pre;
            r_prea   <= w_prea;
            r_act    <= w_act;
            r_no_act <= w_no_act;
            r_cas    <= w_cas;
            r_ref    <= w_ref;
            r_ack    <= w_ack;
            if (w_capture) begin
                r_bg  <= bg_in;
                r_ba  <= ba_in;
                r_row <= row_in;
                r_col <= col_in;
                r_req <= req_in;
            end
        end
    end

    // Row storage needs no reset: an entry is only trusted while its valid bit is set.
    always_ff @(posedge CK_c) begin
        if (w_row_we) r_row_tbl[w_idx] <= r_row;
    end

    assign busy        = r_busy;
    assign pre_rdy     = r_pre;
    assign prea_rdy    = r_prea;
    assign act_rdy     = r_act;
    assign no_act_rdy  = r_no_act;
    assign cas_rdy     = r_cas;
    assign refresh_rdy = r_ref;
    assign refresh_ack = r_ack;
    assign bg_out      = r_bg;
    assign ba_out      = r_ba;
    assign row_out     = r_row;
    assign col_out     = r_col;
    assign req_out     = r_req;
endmodule

// File: tb/tb_row_sched.sv
// Bench for row_sched: expected strobe/busy timelines come from an open-row model
// built on the documented latency arithmetic, compared cycle by cycle.
module tb_row_sched;
    localparam int TRCD = 3;
    localparam int TRP  = 2;
    localparam int TCCD = 2;
    localparam int TRFC = 5;

    logic        CK_c = 1'b0, reset = 1'b0, cmd_rdy = 1'b0, refresh_req = 1'b0;
    logic [2:0]  req_in = 3'd0;
    logic [1:0]  bg_in = 2'd0, ba_in = 2'd0;
    logic [13:0] row_in = 14'd0;
    logic [9:0]  col_in = 10'd0;
    logic        busy, pre_rdy, prea_rdy, act_rdy, no_act_rdy, cas_rdy, refresh_rdy, refresh_ack;
    logic [1:0]  bg_out, ba_out;
    logic [13:0] row_out;
    logic [9:0]  col_out;
    logic [2:0]  req_out;
    logic [6:0]  obs_vec;

    int errors = 0;
    int checks = 0;

    // Expected per-cycle strobes {pre,prea,act,no_act,cas,ref,ack} and busy, indexed by k+n.
    logic [6:0]  exp_vec  [0:63];
    logic        exp_busy [0:63];
    bit          m_open [16];
    logic [13:0] m_row  [16];

    row_sched #(.TRCD(TRCD), .TRP(TRP), .TCCD(TCCD), .TRFC(TRFC)) dut (
        .CK_c(CK_c), .reset(reset), .cmd_rdy(cmd_rdy), .req_in(req_in),
        .bg_in(bg_in), .ba_in(ba_in), .row_in(row_in), .col_in(col_in),
        .refresh_req(refresh_req), .busy(busy), .pre_rdy(pre_rdy), .prea_rdy(prea_rdy),
        .act_rdy(act_rdy), .no_act_rdy(no_act_rdy), .cas_rdy(cas_rdy),
        .refresh_rdy(refresh_rdy), .refresh_ack(refresh_ack), .bg_out(bg_out),
        .ba_out(ba_out), .row_out(row_out), .col_out(col_out), .req_out(req_out)
    );

    assign obs_vec = {pre_rdy, prea_rdy, act_rdy, no_act_rdy, cas_rdy, refresh_rdy, refresh_ack};

    always #5 CK_c = ~CK_c;

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) begin
            exp_vec[i]  = 7'd0;
            exp_busy[i] = 1'b0;
        end
    endtask

    // Request accepted at edge k+base: hit -> no_act@+1, cas@+2; closed -> act@+2;
    // miss -> pre@+2, act TRP later; cas TRCD after act; busy drops TCCD after cas.
    task automatic plan_request(input int base, input logic [2:0] req, input logic [1:0] bg,
                                input logic [1:0] ba, input logic [13:0] row, output int low_n);
        int idx, act_n, cas_n;
        idx = int'({bg, ba});
        if (m_open[idx] && m_row[idx] == row) begin
            exp_vec[base + 1][3] = 1'b1;
            cas_n = base + 2;
        end else begin
            if (m_open[idx]) begin
                exp_vec[base + 2][6] = 1'b1;
                act_n = base + 2 + TRP;
            end else begin
                act_n = base + 2;
            end
            exp_vec[act_n][4] = 1'b1;
            cas_n = act_n + TRCD;
        end
        exp_vec[cas_n][2] = 1'b1;
        low_n = cas_n + TCCD;
        for (int i = base + 1; i < low_n; i++) exp_busy[i] = 1'b1;
        m_open[idx] = !(req == 3'd3 || req == 3'd4);
        m_row[idx]  = row;
    endtask

    // Refresh taken at edge k+base: prea@+1 when any row is open, ref TRP later
    // (or @+1), ack TRFC after ref, busy low the cycle after ack.
    task automatic plan_refresh(input int base, output int ack_n);
        int ref_n;
        bit any_open;
        any_open = 1'b0;
        for (int i = 0; i < 16; i++) any_open |= m_open[i];
        if (any_open) begin
            exp_vec[base + 1][5] = 1'b1;
            ref_n = base + 1 + TRP;
        end else begin
            ref_n = base + 1;
        end
        exp_vec[ref_n][1] = 1'b1;
        ack_n = ref_n + TRFC;
        exp_vec[ack_n][0] = 1'b1;
        for (int i = base + 1; i <= ack_n; i++) exp_busy[i] = 1'b1;
        for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] r, input logic [1:0] g, input logic [1:0] a,
                             input logic [13:0] rw, input logic [9:0] c);
        cmd_rdy = 1'b1;
        req_in  = r;
        bg_in   = g;
        ba_in   = a;
        row_in  = rw;
        col_in  = c;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || obs_vec !== 7'd0 || req_out !== 3'd0 || row_out !== 14'd0 ||
            col_out !== 10'd0 || bg_out !== 2'd0 || ba_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b strobes=%b req_out=%0d row_out=%h, expected 0/0/0/0",
                     busy, obs_vec, req_out, row_out);
        end
        @(negedge CK_c);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
        @(posedge CK_c); #1;
        checks++;
        if (busy !== 1'b0 || obs_vec !== 7'd0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b strobes=%b, expected 0/0000000", busy, obs_vec);
        end
        $display("txn reset done");
    endtask

    task automatic test_directed();
        logic [2:0]  t_req [5] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd1};
        logic [13:0] t_row [5] = '{14'h0055, 14'h0055, 14'h0100, 14'h0100, 14'h0100};
        logic [9:0]  col;
        int last;
        for (int t = 0; t < 5; t++) begin
            clear_exp();
            plan_request(0, t_req[t], 2'd1, 2'd2, t_row[t], last);
            col = 10'(t * 37 + 1);
            @(negedge CK_c);
            drive_req(t_req[t], 2'd1, 2'd2, t_row[t], col);
            @(posedge CK_c); #1;
            cmd_rdy = 1'b0;
            for (int n = 0; n <= last + 1; n++) begin
                if (n > 0) begin @(posedge CK_c); #1; end
                checks++;
                if (obs_vec !== exp_vec[n] || busy !== exp_busy[n]) begin
                    errors++;
                    $display("FAIL directed%0d k+%0d: strobes=%b busy=%b, expected strobes=%b busy=%b",
                             t, n, obs_vec, busy, exp_vec[n], exp_busy[n]);
                end
                if (n == 1) begin
                    checks++;
                    if ({req_out, bg_out, ba_out, row_out, col_out} !== {t_req[t], 2'd1, 2'd2, t_row[t], col}) begin
                        errors++;
                        $display("FAIL directed%0d captured: req=%0d row=%h col=%h, expected req=%0d row=%h col=%h",
                                 t, req_out, row_out, col_out, t_req[t], t_row[t], col);
                    end
                end
            end
            $display("txn directed %0d req=%0d row=%h busy_low_at=k+%0d", t, t_req[t], t_row[t], last);
        end
    endtask

    task automatic test_refresh_with_cmd();
        int ack_n, last;
        clear_exp();
        plan_refresh(0, ack_n);
        plan_request(ack_n + 1, 3'd2, 2'd1, 2'd2, 14'h0100, last);
        @(negedge CK_c);
        drive_req(3'd2, 2'd1, 2'd2, 14'h0100, 10'h155);
        refresh_req = 1'b1;
        @(posedge CK_c); #1;
        refresh_req = 1'b0;
        for (int n = 0; n <= last + 1; n++) begin
            if (n > 0) begin @(posedge CK_c); #1; end
            if (n == ack_n + 1) cmd_rdy = 1'b0;
            checks++;
            if (obs_vec !== exp_vec[n] || busy !== exp_busy[n]) begin
                errors++;
                $display("FAIL refresh_cmd k+%0d: strobes=%b busy=%b, expected strobes=%b busy=%b",
                         n, obs_vec, busy, exp_vec[n], exp_busy[n]);
            end
        end
        $display("txn refresh+cmd ack_at=k+%0d request_busy_low_at=k+%0d", ack_n, last);
    endtask

    task automatic test_refresh_mid_request();
        int ack_n, last;
        clear_exp();
        plan_request(0, 3'd1, 2'd1, 2'd2, 14'h0200, last);
        plan_refresh(last, ack_n);
        @(negedge CK_c);
        drive_req(3'd1, 2'd1, 2'd2, 14'h0200, 10'h0aa);
        @(posedge CK_c); #1;
        cmd_rdy = 1'b0;
        for (int n = 0; n <= ack_n + 2; n++) begin
            if (n > 0) begin @(posedge CK_c); #1; end
            if (n == 2) refresh_req = 1'b1;
            if (n == last) refresh_req = 1'b0;
            checks++;
            if (obs_vec !== exp_vec[n] || busy !== exp_busy[n]) begin
                errors++;
                $display("FAIL refresh_mid k+%0d: strobes=%b busy=%b, expected strobes=%b busy=%b",
                         n, obs_vec, busy, exp_vec[n], exp_busy[n]);
            end
        end
        $display("txn refresh mid-request ack_at=k+%0d", ack_n);
    endtask

    task automatic test_reset_mid_wait();
        int last;
        for (int pass = 0; pass < 2; pass++) begin
            clear_exp();
            plan_request(0, 3'd1, 2'd2, 2'd3, 14'h0007, last);
            if (pass == 0) begin
                @(negedge CK_c);
                drive_req(3'd1, 2'd2, 2'd3, 14'h0007, 10'h011);
            end
            @(posedge CK_c); #1;
            cmd_rdy = 1'b0;
            for (int n = 0; n <= (pass == 0 ? 3 : last + 1); n++) begin
                if (n > 0) begin @(posedge CK_c); #1; end
                checks++;
                if (obs_vec !== exp_vec[n] || busy !== exp_busy[n]) begin
                    errors++;
                    $display("FAIL reset_mid%0d k+%0d: strobes=%b busy=%b, expected strobes=%b busy=%b",
                             pass, n, obs_vec, busy, exp_vec[n], exp_busy[n]);
                end
            end
            if (pass == 0) begin
                reset = 1'b1;
                #1;
                checks++;
                if (busy !== 1'b0 || obs_vec !== 7'd0 || req_out !== 3'd0 || row_out !== 14'd0) begin
                    errors++;
                    $display("FAIL reset_mid_clear: busy=%b strobes=%b req_out=%0d row_out=%h, expected all 0",
                             busy, obs_vec, req_out, row_out);
                end
                for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
                @(negedge CK_c);
                reset = 1'b0;
                drive_req(3'd1, 2'd2, 2'd3, 14'h0007, 10'h012);
            end
            $display("txn reset-in-wait pass %0d", pass);
        end
    endtask

    task automatic test_invalid_req();
        logic [2:0] codes [4] = '{3'd0, 3'd5, 3'd6, 3'd7};
        for (int c = 0; c < 4; c++) begin
            @(negedge CK_c);
            drive_req(codes[c], 2'(c), 2'd1, 14'h0033, 10'h3ff);
            for (int n = 1; n <= 3; n++) begin
                @(posedge CK_c); #1;
                checks++;
                if (busy !== 1'b0 || obs_vec !== 7'd0) begin
                    errors++;
                    $display("FAIL invalid_req%0d cycle %0d: busy=%b strobes=%b, expected 0/0000000",
                             codes[c], n, busy, obs_vec);
                end
            end
            cmd_rdy = 1'b0;
            $display("txn invalid req code %0d ignored check", codes[c]);
        end
    endtask

    task automatic test_random();
        logic [2:0]  r;
        logic [1:0]  g, a;
        logic [13:0] rw;
        logic [9:0]  col;
        int last;
        for (int t = 0; t < 30; t++) begin
            r   = 3'($urandom_range(1, 4));
            g   = 2'($urandom_range(0, 1));
            a   = 2'($urandom_range(0, 1));
            rw  = 14'($urandom_range(0, 2) * 16 + 3);
            col = 10'($urandom_range(0, 1023));
            clear_exp();
            plan_request(0, r, g, a, rw, last);
            @(negedge CK_c);
            drive_req(r, g, a, rw, col);
            @(posedge CK_c); #1;
            cmd_rdy = 1'b0;
            for (int n = 0; n <= last + 1; n++) begin
                if (n > 0) begin @(posedge CK_c); #1; end
                checks++;
                if (obs_vec !== exp_vec[n] || busy !== exp_busy[n]) begin
                    errors++;
                    $display("FAIL random%0d k+%0d: strobes=%b busy=%b, expected strobes=%b busy=%b",
                             t, n, obs_vec, busy, exp_vec[n], exp_busy[n]);
                end
                if (n == 2) begin
                    checks++;
                    if ({req_out, bg_out, ba_out, row_out, col_out} !== {r, g, a, rw, col}) begin
                        errors++;
                        $display("FAIL random%0d captured: req=%0d bg=%0d ba=%0d row=%h, expected %0d/%0d/%0d/%h",
                                 t, req_out, bg_out, ba_out, row_out, r, g, a, rw);
                    end
                end
            end
            $display("txn random %0d req=%0d bg=%0d ba=%0d row=%h busy_low_at=k+%0d", t, r, g, a, rw, last);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_refresh_with_cmd();
        test_refresh_mid_request();
        test_reset_mid_wait();
        test_invalid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
